// File: rtl/piano_tone_gen_pkg.sv
// Shared note codes and half-period table for the piano tone path.
// Sequencer, keyboard and tone generator all use these codes.
package piano_tone_gen_pkg;

    typedef enum logic [3:0] {
        NOTE_C5   = 4'd0,
        NOTE_B    = 4'd1,
        NOTE_A    = 4'd2,
        NOTE_G    = 4'd3,
        NOTE_F    = 4'd4,
        NOTE_E    = 4'd5,
        NOTE_D    = 4'd6,
        NOTE_C4   = 4'd7,
        NOTE_NONE = 4'd8
    } note_e;

    typedef enum logic {
        ST_IDLE,
        ST_TONE
    } tone_state_e;

    localparam logic [31:0] HP_C5 = 32'd95557;
    localparam logic [31:0] HP_B  = 32'd101239;
    localparam logic [31:0] HP_A  = 32'd113636;
    localparam logic [31:0] HP_G  = 32'd127551;
    localparam logic [31:0] HP_F  = 32'd143172;
    localparam logic [31:0] HP_E  = 32'd151685;
    localparam logic [31:0] HP_D  = 32'd170265;
    localparam logic [31:0] HP_C4 = 32'd191110;

    // Codes above NOTE_NONE carry no pitch and are treated as silence.
    function automatic logic [3:0] fold_note(input logic [3:0] code);
        return (code > 4'd8) ? NOTE_NONE : code;
    endfunction

    // Counter load value (half-period minus one); zero for non-pitched codes.
    function automatic logic [31:0] hp_load(
        input logic [3:0]  code,
        input int unsigned shift
    );
        logic [31:0] v;
        case (code)
            NOTE_C5: v = HP_C5;
            NOTE_B:  v = HP_B;
            NOTE_A:  v = HP_A;
            NOTE_G:  v = HP_G;
            NOTE_F:  v = HP_F;
            NOTE_E:  v = HP_E;
            NOTE_D:  v = HP_D;
            NOTE_C4: v = HP_C4;
            default: v = 32'd0;
        endcase
        return (v == 32'd0) ? 32'd0 : ((v >> shift) - 32'd1);
    endfunction

endpackage

// File: rtl/piano_tone_gen_note_sync_qual.sv
// Note-code input conditioning: 3-flop synchroniser, stability
// qualifier and folding of out-of-range codes to "none".
module piano_tone_gen_note_sync_qual
    import piano_tone_gen_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_note,
    output logic [3:0] o_q
);

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_s3;
    logic [3:0] r_q;
    logic [3:0] w_q;

    // A code is accepted only once it has been stable for two synced samples.
    always_comb begin
        w_q = r_q;
        if (r_s2 == r_s3) begin
            w_q = fold_note(r_s2);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= NOTE_NONE;
            r_s2 <= NOTE_NONE;
            r_s3 <= NOTE_NONE;
            r_q  <= NOTE_NONE;
        end else begin
            r_s1 <= i_note;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_q  <= w_q;
        end
    end

    assign o_q = w_q;

endmodule

// File: rtl/piano_tone_gen.sv
// Square-wave tone generator: pitch changes only at half-period
// boundaries, output gated by an 8-step volume PWM.
module piano_tone_gen
    import piano_tone_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SIM_SHIFT = 0,
    parameter int unsigned HP_W      = 18
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] note,
    input  logic [2:0] VOLUME,
    output logic       SPEAKER,
    output logic       PLAYING,
    output logic [3:0] CUR_NOTE
);

    tone_state_e r_state;
    tone_state_e w_state_nxt;
    logic [HP_W-1:0] r_cnt;
    logic [HP_W-1:0] w_cnt_nxt;
    logic            r_wave;
    logic            w_wave_nxt;
    logic [3:0]      r_cur;
    logic [3:0]      w_cur_nxt;
    logic [2:0]      r_pwm;
    logic            r_spk;

    logic [3:0]      w_q;
    logic            w_q_valid;
    logic            w_term;
    logic            w_same;
    logic            w_change;
    logic [HP_W-1:0] w_load_q;
    logic [HP_W-1:0] w_load_cur;
    logic            w_unused_clk_hz;

    // The table is fixed at 100 MHz; the clock rate is informational only.
    assign w_unused_clk_hz = (CLK_HZ != 0);

    piano_tone_gen_note_sync_qual u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_note  (note),
        .o_q     (w_q)
    );

    assign w_q_valid  = (w_q < 4'd8);
    assign w_term     = (r_cnt == '0);
    assign w_same     = (w_q == r_cur);
    assign w_change   = w_q_valid && !w_same;
    assign w_load_q   = HP_W'(hp_load(w_q, SIM_SHIFT));
    assign w_load_cur = HP_W'(hp_load(r_cur, SIM_SHIFT));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wave_nxt  = r_wave;
        w_cur_nxt   = r_cur;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_wave_nxt = 1'b0;
                if (w_q_valid) begin
                    w_state_nxt = ST_TONE;
                    w_cur_nxt   = w_q;
                    w_cnt_nxt   = w_load_q;
                    w_wave_nxt  = 1'b1;
                end
            end
            ST_TONE: begin
                if (!w_term) begin
                    w_cnt_nxt = r_cnt - HP_W'(1);
                end else begin
                    // Pitch changes keep phase: the wave still toggles here.
                    unique case (1'b1)
                        w_same: begin
                            w_wave_nxt = ~r_wave;
                            w_cnt_nxt  = w_load_cur;
                        end
                        w_change: begin
                            w_wave_nxt = ~r_wave;
                            w_cur_nxt  = w_q;
                            w_cnt_nxt  = w_load_q;
                        end
                        default: begin
                            w_wave_nxt  = 1'b0;
                            w_cur_nxt   = NOTE_NONE;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wave  <= 1'b0;
            r_cur   <= NOTE_NONE;
            r_pwm   <= '0;
            r_spk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wave  <= w_wave_nxt;
            r_cur   <= w_cur_nxt;
            r_pwm   <= r_pwm + 3'd1;
            r_spk   <= r_wave & (r_pwm < VOLUME);
        end
    end

    assign SPEAKER  = r_spk;
    assign PLAYING  = (r_state == ST_TONE);
    assign CUR_NOTE = r_cur;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Bench for piano_tone_gen: per-cycle comparison against a
// behavioural model of phases, sync delay and volume PWM.
module tb_piano_tone_gen;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [3:0] note = 4'd8;
    logic [2:0] VOLUME = 3'd7;
    wire        SPEAKER;
    wire        PLAYING;
    wire  [3:0] CUR_NOTE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_hist[$];
    logic [3:0] m_qh;
    logic [3:0] m_cur;
    bit         m_play;
    bit         m_wave;
    bit         m_spk;
    int         m_left;
    int         m_pwm;

    piano_tone_gen #(
        .CLK_HZ    (100_000_000),
        .SIM_SHIFT (10),
        .HP_W      (18)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .note     (note),
        .VOLUME   (VOLUME),
        .SPEAKER  (SPEAKER),
        .PLAYING  (PLAYING),
        .CUR_NOTE (CUR_NOTE)
    );

    always #5 CLK = ~CLK;

    function automatic int hp_of(input int code);
        int base [8] = '{95557, 101239, 113636, 127551,
                         143172, 151685, 170265, 191110};
        return base[code] >> 10;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        repeat (3) m_hist.push_back(4'd8);
        m_qh   = 4'd8;
        m_cur  = 4'd8;
        m_play = 1'b0;
        m_wave = 1'b0;
        m_spk  = 1'b0;
        m_left = 0;
        m_pwm  = 0;
    endtask

    // One clock edge: m_hist holds the last three captured codes, oldest first.
    task automatic model_edge();
        logic [3:0] q;
        if (m_hist[1] == m_hist[0])
            q = (m_hist[1] > 4'd8) ? 4'd8 : m_hist[1];
        else
            q = m_qh;
        m_qh  = q;
        m_spk = m_wave && (m_pwm < int'(VOLUME));
        if (!m_play) begin
            if (q < 4'd8) begin
                m_play = 1'b1;
                m_cur  = q;
                m_wave = 1'b1;
                m_left = hp_of(int'(q));
            end
        end else if (m_left > 1) begin
            m_left--;
        end else if (q == m_cur) begin
            m_wave = !m_wave;
            m_left = hp_of(int'(m_cur));
        end else if (q < 4'd8) begin
            m_cur  = q;
            m_wave = !m_wave;
            m_left = hp_of(int'(q));
        end else begin
            m_play = 1'b0;
            m_wave = 1'b0;
            m_cur  = 4'd8;
            m_left = 0;
        end
        m_pwm = (m_pwm + 1) % 8;
        m_hist.push_back(note);
        void'(m_hist.pop_front());
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        note   = 4'd2;
        VOLUME = 3'd7;
        #2 RESET_N = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({SPEAKER, PLAYING, CUR_NOTE} !== 6'b00_1000) begin
            n_bad++;
            $display("FAIL reset_state spk/play/cur=%b/%b/%0d want 0/0/8",
                     SPEAKER, PLAYING, CUR_NOTE);
        end
        RESET_N = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (SPEAKER !== (i == 5)) begin
                n_bad++;
                $display("FAIL first_rise cycle %0d spk=%b want %b",
                         i, SPEAKER, (i == 5));
            end
        end
        for (int i = 0; i < 240; i++) begin
            tick();
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL tone_a t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
        end
        n_cmp++;
        if ({PLAYING, CUR_NOTE} !== 5'b1_0010) begin
            n_bad++;
            $display("FAIL tone_a_status play/cur=%b/%0d want 1/2",
                     PLAYING, CUR_NOTE);
        end
    endtask

    task automatic test_pitch_change();
        int  lat;
        int  want;
        int  cnt;
        bit  hit;
        want = hp_of(2) - int'($urandom_range(20, 80));
        hit  = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL pc_wait t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
            hit = m_wave && (m_left == want);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL pc_timeout found=%b want 1", hit);
        end
        lat  = m_left;
        note = 4'd5;
        cnt  = 0;
        for (int i = 0; i < 400 && CUR_NOTE !== 4'd5; i++) begin
            tick();
            cnt++;
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL pc_track t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
        end
        n_cmp++;
        if (cnt != lat) begin
            n_bad++;
            $display("FAIL pc_latency cycles=%0d want %0d", cnt, lat);
        end
        for (int i = 0; i < 2 * hp_of(5) + 20; i++) begin
            tick();
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL tone_e t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0] codes [2] = '{4'd8, 4'd12};
        for (int r = 0; r < 2; r++) begin
            note = 4'd2;
            for (int i = 0; i < 60; i++) tick();
            note = codes[r];
            for (int i = 0; i < 400 && PLAYING !== 1'b0; i++) begin
                tick();
                n_cmp++;
                if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                    n_bad++;
                    $display("FAIL stop_track t=%0t got %b/%b/%0d want %b/%b/%0d",
                             $time, SPEAKER, PLAYING, CUR_NOTE,
                             m_spk, m_play, m_cur);
                end
            end
            n_cmp++;
            if ({PLAYING, CUR_NOTE} !== 5'b0_1000) begin
                n_bad++;
                $display("FAIL stop_%0d play/cur=%b/%0d want 0/8",
                         codes[r], PLAYING, CUR_NOTE);
            end
            tick();
            n_cmp++;
            if (SPEAKER !== 1'b0) begin
                n_bad++;
                $display("FAIL stop_spk_%0d spk=%b want 0", codes[r], SPEAKER);
            end
        end
    endtask

    task automatic test_glitch();
        int  width;
        bit  hit;
        note = 4'd2;
        for (int g = 0; g < 2; g++) begin
            width = g + 1;
            hit   = 1'b0;
            for (int i = 0; i < 400 && !hit; i++) begin
                tick();
                n_cmp++;
                if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                    n_bad++;
                    $display("FAIL gl_wait t=%0t got %b/%b/%0d want %b/%b/%0d",
                             $time, SPEAKER, PLAYING, CUR_NOTE,
                             m_spk, m_play, m_cur);
                end
                hit = m_play && (m_left == 4) && (m_cur == 4'd2);
            end
            n_cmp++;
            if (!hit) begin
                n_bad++;
                $display("FAIL gl_timeout found=%b want 1", hit);
            end
            note = 4'd5;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (i == width - 1) note = 4'd2;
            end
            n_cmp++;
            if (CUR_NOTE !== ((width == 1) ? 4'd2 : 4'd5)) begin
                n_bad++;
                $display("FAIL glitch_w%0d cur=%0d want %0d", width, CUR_NOTE,
                         (width == 1) ? 2 : 5);
            end
            for (int i = 0; i < 320; i++) begin
                tick();
                n_cmp++;
                if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                    n_bad++;
                    $display("FAIL gl_track t=%0t got %b/%b/%0d want %b/%b/%0d",
                             $time, SPEAKER, PLAYING, CUR_NOTE,
                             m_spk, m_play, m_cur);
                end
            end
        end
    endtask

    task automatic test_volume();
        int  ones;
        bit  hit;
        note   = 4'd2;
        VOLUME = 3'd0;
        for (int i = 0; i < 250; i++) begin
            tick();
            n_cmp++;
            if ({SPEAKER, PLAYING} !== 2'b01) begin
                n_bad++;
                $display("FAIL mute t=%0t spk/play=%b/%b want 0/1",
                         $time, SPEAKER, PLAYING);
            end
        end
        VOLUME = 3'd4;
        hit    = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            hit = m_wave && (m_left == hp_of(2) - 2);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL vol_timeout found=%b want 1", hit);
        end
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            ones += int'(SPEAKER === 1'b1);
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL vol_track t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
        end
        n_cmp++;
        if (ones != 32) begin
            n_bad++;
            $display("FAIL vol4_duty highs=%0d want 32", ones);
        end
        VOLUME = 3'd7;
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 24; s++) begin
            note   = 4'($urandom_range(0, 15));
            VOLUME = 3'($urandom_range(0, 7));
            hold   = int'($urandom_range(1, 200));
            for (int i = 0; i < hold; i++) begin
                tick();
                n_cmp++;
                if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                    n_bad++;
                    $display("FAIL rnd t=%0t got %b/%b/%0d want %b/%b/%0d",
                             $time, SPEAKER, PLAYING, CUR_NOTE,
                             m_spk, m_play, m_cur);
                end
            end
        end
        VOLUME = 3'd7;
    endtask

    task automatic test_reset_mid();
        bit hit;
        note = 4'd2;
        hit  = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            tick();
            hit = m_wave && m_play && (SPEAKER === 1'b1);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL rm_timeout found=%b want 1", hit);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++;
        if ({SPEAKER, PLAYING, CUR_NOTE} !== 6'b00_1000) begin
            n_bad++;
            $display("FAIL async_reset spk/play/cur=%b/%b/%0d want 0/0/8",
                     SPEAKER, PLAYING, CUR_NOTE);
        end
        note = 4'd7;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (SPEAKER !== (i == 5)) begin
                n_bad++;
                $display("FAIL c4_rise cycle %0d spk=%b want %b",
                         i, SPEAKER, (i == 5));
            end
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            n_cmp++;
            if ({SPEAKER, PLAYING, CUR_NOTE} !== {m_spk, m_play, m_cur}) begin
                n_bad++;
                $display("FAIL tone_c4 t=%0t got %b/%b/%0d want %b/%b/%0d",
                         $time, SPEAKER, PLAYING, CUR_NOTE,
                         m_spk, m_play, m_cur);
            end
        end
        n_cmp++;
        if ({PLAYING, CUR_NOTE} !== 5'b1_0111) begin
            n_bad++;
            $display("FAIL c4_status play/cur=%b/%0d want 1/7",
                     PLAYING, CUR_NOTE);
        end
    endtask

    initial begin
        test_reset();
        test_pitch_change();
        test_stop();
        test_glitch();
        test_volume();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
